// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// Only the request/response bus is grouped here; pipeline sideband stays on plain ports.
interface mem_access_if;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_we;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req, dm_addr, dm_we, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_addr, dm_we, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_access.sv
// Pipeline memory-access stage: issues aligned loads/stores on the data bus, stalls until ack.
// Define MEM_TIMEOUT_EN to abort a BUSY access after 16 cycles without ack (bus_err_out).
module mem_access (
    input  logic         clk,
    input  logic         rst,
    input  logic         write,
    input  logic         flush,
    input  logic [31:0]  exe_data,
    input  logic [31:0]  busB,
    input  logic [31:0]  pc,
    input  logic [3:0]   memReadEn,
    input  logic [3:0]   memWriteEn,
    input  logic         load_signed,
    input  logic         mem_to_reg,
    input  logic         reg_wen,
    input  logic [4:0]   reg_num,
    mem_access_if.master dm,
    output logic         stall_out,
    output logic [31:0]  wb_data_out,
    output logic         reg_wen_out,
    output logic [4:0]   reg_num_out,
    output logic [31:0]  pc_out,
    output logic         addr_err_out,
    output logic         bus_err_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  we_q, rd_mask_q;
    logic [1:0]  off_q;
    logic        signed_q, killed_q;

    logic [31:0] wb_data_q;
    logic        reg_wen_q, addr_err_q, bus_err_q;
    logic [4:0]  reg_num_q;
    logic [31:0] pc_q;

    logic [3:0]  size_mask;
    logic        misaligned, access_req, timeout;
    logic [31:0] addr_c, wdata_c, load_data;
    logic [3:0]  we_c;
    logic        req_c, stall_c, cap_rdata, enter_busy, capture;

    assign size_mask  = memReadEn | memWriteEn;
    assign misaligned = ((size_mask == 4'b0011) && exe_data[0]) ||
                        ((size_mask == 4'b1111) && (exe_data[1:0] != 2'b00));
    assign access_req = (size_mask != 4'b0000) && !flush && !misaligned;

    assign addr_c = {exe_data[31:2], 2'b00};
    assign we_c   = memWriteEn << exe_data[1:0];

    always_comb begin
        case (memWriteEn)
            4'b0001: wdata_c = {4{busB[7:0]}};
            4'b0011: wdata_c = {2{busB[15:0]}};
            default: wdata_c = busB;
        endcase
    end

    // Raw read word: straight off the bus on the ack cycle, otherwise the copy held in DONE.
    function automatic logic [31:0] format_load(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [3:0] mask, input logic sgn);
        logic [31:0] lane;
        lane = raw >> {off, 3'b000};
        case (mask)
            4'b0001: return {{24{sgn & lane[7]}}, lane[7:0]};
            4'b0011: return {{16{sgn & lane[15]}}, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    assign load_data = format_load((state_q == BUSY) ? dm.dm_rdata : rdata_q,
                                   off_q, rd_mask_q, signed_q);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] tmo_q, tmo_d;

    assign timeout = (state_q == BUSY) && !dm.dm_ack && (tmo_q == 4'hF);

    always_comb begin
        tmo_d = tmo_q;
        if (enter_busy)
            tmo_d = 4'h0;
        else if (state_q == BUSY)
            tmo_d = tmo_q + 4'h1;
    end

    always_ff @(posedge clk) begin
        if (!rst) tmo_q <= 4'h0;
        else      tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        cap_rdata  = 1'b0;
        enter_busy = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_req) begin
                    req_c      = 1'b1;
                    stall_c    = 1'b1;
                    enter_busy = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                req_c = 1'b1;
                if (timeout) begin
                    req_c   = 1'b0;
                    state_d = IDLE;
                end else if (dm.dm_ack) begin
                    cap_rdata = 1'b1;
                    state_d   = write ? IDLE : DONE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            DONE: begin
                if (write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the request combinationally so an outstanding access drops in the reset cycle.
    assign dm.dm_req   = rst & req_c;
    assign dm.dm_addr  = (state_q == IDLE) ? addr_c  : addr_q;
    assign dm.dm_we    = (state_q == IDLE) ? we_c    : we_q;
    assign dm.dm_wdata = (state_q == IDLE) ? wdata_c : wdata_q;
    assign stall_out   = rst & stall_c;
    assign capture     = write && !stall_c;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            rd_mask_q   <= '0;
            off_q       <= '0;
            signed_q    <= 1'b0;
            rdata_q     <= '0;
            killed_q    <= 1'b0;
            wb_data_q   <= '0;
            reg_wen_q   <= 1'b0;
            reg_num_q   <= '0;
            pc_q        <= '0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enter_busy) begin
                addr_q    <= addr_c;
                we_q      <= we_c;
                wdata_q   <= wdata_c;
                rd_mask_q <= memReadEn;
                off_q     <= exe_data[1:0];
                signed_q  <= load_signed;
            end
            if (cap_rdata) rdata_q <= dm.dm_rdata;
            // A flush seen mid-access must still squash the write-back once the ack arrives.
            killed_q <= (state_d != IDLE) && (killed_q || ((state_q != IDLE) && flush));
            if (capture) begin
                wb_data_q  <= mem_to_reg ? load_data : exe_data;
                reg_wen_q  <= reg_wen & !flush & !killed_q & !misaligned & !timeout;
                reg_num_q  <= reg_num;
                pc_q       <= pc;
                addr_err_q <= misaligned;
                bus_err_q  <= timeout;
            end
        end
    end

    assign wb_data_out  = wb_data_q;
    assign reg_wen_out  = reg_wen_q;
    assign reg_num_out  = reg_num_q;
    assign pc_out       = pc_q;
    assign addr_err_out = addr_err_q;
    assign bus_err_out  = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized loads/stores against a byte-level model.
// Build with MEM_TIMEOUT_EN defined to exercise the bus timeout instead of the indefinite wait.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        write, flush;
    logic [31:0] exe_data, busB, pc;
    logic [3:0]  memReadEn, memWriteEn;
    logic        load_signed, mem_to_reg, reg_wen;
    logic [4:0]  reg_num;
    logic        stall_out, reg_wen_out, addr_err_out, bus_err_out;
    logic [31:0] wb_data_out, pc_out;
    logic [4:0]  reg_num_out;

    int passed = 0;
    int total  = 0;

    mem_access_if dm_bus ();

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .flush        (flush),
        .exe_data     (exe_data),
        .busB         (busB),
        .pc           (pc),
        .memReadEn    (memReadEn),
        .memWriteEn   (memWriteEn),
        .load_signed  (load_signed),
        .mem_to_reg   (mem_to_reg),
        .reg_wen      (reg_wen),
        .reg_num      (reg_num),
        .dm           (dm_bus),
        .stall_out    (stall_out),
        .wb_data_out  (wb_data_out),
        .reg_wen_out  (reg_wen_out),
        .reg_num_out  (reg_num_out),
        .pc_out       (pc_out),
        .addr_err_out (addr_err_out),
        .bus_err_out  (bus_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, data, pc;
        logic [3:0]  rd, wr;
        logic        sgn, m2r, wen, fl;
        logic [4:0]  rn;
    } op_t;

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int mask_bytes(input logic [3:0] m);
        return (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : (m == 4'b1111) ? 4 : 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                             input int nbytes, input bit sgn);
        logic [7:0] b [4];
        longint v = 0;
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        for (int i = 0; i < nbytes; i++) v = v + (longint'(b[off + i]) << (8 * i));
        if (sgn && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_we(input int off, input int nbytes);
        logic [3:0] we = '0;
        for (int i = 0; i < nbytes; i++) we[off + i] = 1'b1;
        return we;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] src, input int nbytes);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = src[8*(j % nbytes) +: 8];
        return w;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o);
        exe_data    = o.addr;
        busB        = o.data;
        pc          = o.pc;
        memReadEn   = o.rd;
        memWriteEn  = o.wr;
        load_signed = o.sgn;
        mem_to_reg  = o.m2r;
        reg_wen     = o.wen;
        flush       = o.fl;
        reg_num     = o.rn;
    endtask

    function automatic op_t mk(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] rd, input logic [3:0] wr,
                               input logic sgn, input logic m2r);
        op_t o;
        o.addr = addr; o.data = data; o.pc = addr ^ 32'h0000_4000;
        o.rd = rd; o.wr = wr; o.sgn = sgn; o.m2r = m2r;
        o.wen = 1'b1; o.fl = 1'b0; o.rn = addr[6:2];
        return o;
    endfunction

    task automatic nop();
        drive(mk(32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        write = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        write = 1'b1;
        dm_bus.dm_ack = 1'b1;
        dm_bus.dm_rdata = 32'hFFFF_FFFF;
        drive(mk(32'h100, 32'h1, 4'b1111, 4'b0000, 1'b0, 1'b1));
        step(); step();
        total++; if (dm_bus.dm_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dm_bus.dm_req); else passed++;
        total++; if (wb_data_out !== 32'h0) $display("FAIL reset_wb: got %h want 0", wb_data_out); else passed++;
        total++; if ({reg_wen_out, addr_err_out, bus_err_out} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {reg_wen_out, addr_err_out, bus_err_out}); else passed++;
        total++; if ({reg_num_out, pc_out} !== 37'h0) $display("FAIL reset_num_pc: got %h want 0", {reg_num_out, pc_out}); else passed++;
        dm_bus.dm_ack = 1'b0;
        nop();
        rst = 1'b1;
        step();
        total++; if (stall_out !== 1'b0) $display("FAIL reset_idle_stall: got %b want 0", stall_out); else passed++;
    endtask

    task automatic test_word_load();
        int stalls = 0;
        op_t o = mk(32'h100, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1);
        o.rn = 5'd5; o.pc = 32'h40;
        drive(o);
        #1;
        total++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_addr !== 32'h100 || dm_bus.dm_we !== 4'b0000)
            $display("FAIL wload_issue: got req=%b addr=%h we=%b want 1/00000100/0000", dm_bus.dm_req, dm_bus.dm_addr, dm_bus.dm_we); else passed++;
        for (int c = 0; c < 3; c++) begin
            if (stall_out === 1'b1) stalls++;
            step();
            total++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_addr !== 32'h100)
                $display("FAIL wload_hold: got req=%b addr=%h want 1/00000100", dm_bus.dm_req, dm_bus.dm_addr); else passed++;
        end
        dm_bus.dm_ack = 1'b1;
        dm_bus.dm_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (stall_out !== 1'b0) $display("FAIL wload_ack_stall: got %b want 0", stall_out); else passed++;
        step();
        dm_bus.dm_ack = 1'b0;
        nop();
        total++; if (stalls != 3) $display("FAIL wload_stalls: got %0d want 3", stalls); else passed++;
        total++; if (wb_data_out !== 32'hDEAD_BEEF) $display("FAIL wload_wb: got %h want deadbeef", wb_data_out); else passed++;
        total++; if (reg_wen_out !== 1'b1 || reg_num_out !== 5'd5 || pc_out !== 32'h40)
            $display("FAIL wload_meta: got wen=%b rn=%0d pc=%h want 1/5/00000040", reg_wen_out, reg_num_out, pc_out); else passed++;
    endtask

    task automatic test_byte_load_sign();
        logic [31:0] want [2];
        want[0] = 32'h0000_0080;
        want[1] = 32'hFFFF_FF80;
        for (int s = 0; s < 2; s++) begin
            drive(mk(32'h103, 32'h0, 4'b0001, 4'b0000, s[0], 1'b1));
            #1;
            total++; if (dm_bus.dm_addr !== 32'h100) $display("FAIL bload_addr: got %h want 00000100", dm_bus.dm_addr); else passed++;
            step();
            dm_bus.dm_ack = 1'b1;
            dm_bus.dm_rdata = 32'h8011_2233;
            step();
            dm_bus.dm_ack = 1'b0;
            nop();
            total++; if (wb_data_out !== want[s]) $display("FAIL bload_sign%0d: got %h want %h", s, wb_data_out, want[s]); else passed++;
        end
    endtask

    task automatic test_half_store();
        drive(mk(32'h202, 32'h1234_ABCD, 4'b0000, 4'b0011, 1'b0, 1'b0));
        #1;
        total++; if (dm_bus.dm_addr !== 32'h200 || dm_bus.dm_we !== 4'b1100 || dm_bus.dm_wdata !== 32'hABCD_ABCD)
            $display("FAIL hstore_issue: got %h/%b/%h want 00000200/1100/abcdabcd", dm_bus.dm_addr, dm_bus.dm_we, dm_bus.dm_wdata); else passed++;
        step();
        total++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_we !== 4'b1100 || dm_bus.dm_wdata !== 32'hABCD_ABCD)
            $display("FAIL hstore_hold: got %b/%b/%h want 1/1100/abcdabcd", dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_wdata); else passed++;
        dm_bus.dm_ack = 1'b1;
        step();
        dm_bus.dm_ack = 1'b0;
        nop();
        total++; if (wb_data_out !== 32'h202 || reg_wen_out !== 1'b1) $display("FAIL hstore_wb: got %h/%b want 00000202/1", wb_data_out, reg_wen_out); else passed++;
    endtask

    task automatic test_misaligned();
        drive(mk(32'h101, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        #1;
        total++; if (dm_bus.dm_req !== 1'b0 || stall_out !== 1'b0) $display("FAIL misal_req: got req=%b stall=%b want 0/0", dm_bus.dm_req, stall_out); else passed++;
        step();
        total++; if (addr_err_out !== 1'b1 || reg_wen_out !== 1'b0) $display("FAIL misal_err: got err=%b wen=%b want 1/0", addr_err_out, reg_wen_out); else passed++;
        nop();
        step();
    endtask

    task automatic test_done_hold();
        drive(mk(32'h5555_0000, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        step();
        drive(mk(32'h300, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        step();
        write = 1'b0;
        dm_bus.dm_ack = 1'b1;
        dm_bus.dm_rdata = 32'hCAFE_F00D;
        step();
        dm_bus.dm_ack = 1'b0;
        dm_bus.dm_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            total++; if (dm_bus.dm_req !== 1'b0 || stall_out !== 1'b0 || wb_data_out !== 32'h5555_0000)
                $display("FAIL done_hold: got req=%b stall=%b wb=%h want 0/0/55550000", dm_bus.dm_req, stall_out, wb_data_out); else passed++;
            step();
        end
        write = 1'b1;
        step();
        nop();
        total++; if (wb_data_out !== 32'hCAFE_F00D || reg_wen_out !== 1'b1) $display("FAIL done_capture: got %h/%b want cafef00d/1", wb_data_out, reg_wen_out); else passed++;
    endtask

    task automatic test_reset_mid_busy();
        drive(mk(32'h400, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        step();
        rst = 1'b0;
        #1;
        total++; if (dm_bus.dm_req !== 1'b0) $display("FAIL rstbusy_req: got %b want 0", dm_bus.dm_req); else passed++;
        dm_bus.dm_ack = 1'b1;
        step();
        dm_bus.dm_ack = 1'b0;
        total++; if (wb_data_out !== 32'h0 || reg_wen_out !== 1'b0 || pc_out !== 32'h0)
            $display("FAIL rstbusy_out: got %h/%b/%h want 0/0/0", wb_data_out, reg_wen_out, pc_out); else passed++;
        rst = 1'b1;
        drive(mk(32'h404, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        #1;
        total++; if (dm_bus.dm_req !== 1'b1 || stall_out !== 1'b1) $display("FAIL rstbusy_idle: got req=%b stall=%b want 1/1", dm_bus.dm_req, stall_out); else passed++;
        step();
        dm_bus.dm_ack = 1'b1;
        dm_bus.dm_rdata = 32'h1357_9BDF;
        step();
        dm_bus.dm_ack = 1'b0;
        nop();
        total++; if (wb_data_out !== 32'h1357_9BDF) $display("FAIL rstbusy_next: got %h want 13579bdf", wb_data_out); else passed++;
    endtask

    task automatic test_flush_busy();
        drive(mk(32'h500, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        step();
        flush = 1'b1;
        #1;
        total++; if (dm_bus.dm_req !== 1'b1 || stall_out !== 1'b1) $display("FAIL flush_busy_req: got req=%b stall=%b want 1/1", dm_bus.dm_req, stall_out); else passed++;
        step();
        flush = 1'b0;
        step();
        total++; if (dm_bus.dm_req !== 1'b1) $display("FAIL flush_busy_wait: got %b want 1", dm_bus.dm_req); else passed++;
        dm_bus.dm_ack = 1'b1;
        step();
        dm_bus.dm_ack = 1'b0;
        nop();
        total++; if (reg_wen_out !== 1'b0) $display("FAIL flush_busy_wen: got %b want 0", reg_wen_out); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            op_t o;
            int sz, nb, off, wait_n;
            bit is_load, aligned, req, misal;
            logic [31:0] rdata, exp_wb;
            sz = $urandom_range(0, 3);
            nb = (sz == 0) ? 0 : (1 << (sz - 1));
            is_load = $urandom_range(0, 1);
            o = mk($urandom, $urandom, 4'b0000, 4'b0000, $urandom_range(0, 1), 1'b0);
            if (nb != 0) begin
                if (is_load) o.rd = (nb == 1) ? 4'b0001 : (nb == 2) ? 4'b0011 : 4'b1111;
                else         o.wr = (nb == 1) ? 4'b0001 : (nb == 2) ? 4'b0011 : 4'b1111;
            end
            o.m2r = (nb != 0) && is_load && ($urandom_range(0, 3) != 0);
            o.wen = $urandom_range(0, 1);
            o.fl  = ($urandom_range(0, 7) == 0);
            o.pc  = $urandom;
            off     = int'(o.addr[1:0]);
            aligned = (nb == 0) || (off % nb == 0);
            misal   = (nb != 0) && !aligned;
            req     = (nb != 0) && !o.fl && aligned;
            wait_n  = $urandom_range(0, 3);
            rdata   = $urandom;
            drive(o);
            #1;
            total++; if (dm_bus.dm_req !== req || stall_out !== req)
                $display("FAIL rnd_req%0d: got req=%b stall=%b want %b", n, dm_bus.dm_req, stall_out, req); else passed++;
            if (req) begin
                total++; if (dm_bus.dm_addr !== {o.addr[31:2], 2'b00} ||
                             dm_bus.dm_we !== (is_load ? 4'b0000 : ref_we(off, nb)) ||
                             (!is_load && dm_bus.dm_wdata !== ref_wdata(o.data, nb)))
                    $display("FAIL rnd_bus%0d: got %h/%b/%h want %h/%b/%h", n, dm_bus.dm_addr, dm_bus.dm_we, dm_bus.dm_wdata,
                             {o.addr[31:2], 2'b00}, is_load ? 4'b0000 : ref_we(off, nb), ref_wdata(o.data, nb)); else passed++;
                step();
                for (int w = 0; w < wait_n; w++) begin
                    total++; if (stall_out !== 1'b1 || dm_bus.dm_req !== 1'b1)
                        $display("FAIL rnd_wait%0d: got stall=%b req=%b want 1/1", n, stall_out, dm_bus.dm_req); else passed++;
                    step();
                end
                dm_bus.dm_ack = 1'b1;
                dm_bus.dm_rdata = rdata;
                step();
                dm_bus.dm_ack = 1'b0;
            end else begin
                step();
            end
            exp_wb = o.m2r ? ref_load(rdata, off, nb, o.sgn) : o.addr;
            if (!o.m2r || req) begin
                total++; if (wb_data_out !== exp_wb) $display("FAIL rnd_wb%0d: got %h want %h", n, wb_data_out, exp_wb); else passed++;
            end
            total++; if (reg_wen_out !== (o.wen && !o.fl && !misal) || addr_err_out !== misal ||
                         reg_num_out !== o.rn || pc_out !== o.pc)
                $display("FAIL rnd_meta%0d: got wen=%b err=%b rn=%0d pc=%h want %b/%b/%0d/%h", n, reg_wen_out, addr_err_out,
                         reg_num_out, pc_out, o.wen && !o.fl && !misal, misal, o.rn, o.pc); else passed++;
        end
        nop();
        step();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int k = 1;
        drive(mk(32'h600, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        step();
        while (dm_bus.dm_req === 1'b1 && k < 40) begin
            step();
            k++;
        end
        total++; if (k != 16 || stall_out !== 1'b0) $display("FAIL timeout_drop: got cycle=%0d stall=%b want 16/0", k, stall_out); else passed++;
        step();
        nop();
        total++; if (bus_err_out !== 1'b1 || reg_wen_out !== 1'b0) $display("FAIL timeout_err: got err=%b wen=%b want 1/0", bus_err_out, reg_wen_out); else passed++;
        step();
    endtask
`else
    task automatic test_no_timeout();
        int drops = 0;
        drive(mk(32'h600, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b1));
        step();
        for (int c = 0; c < 24; c++) begin
            if (dm_bus.dm_req !== 1'b1 || stall_out !== 1'b1) drops++;
            step();
        end
        total++; if (drops != 0) $display("FAIL notimeout_wait: got %0d dropped cycles want 0", drops); else passed++;
        dm_bus.dm_ack = 1'b1;
        dm_bus.dm_rdata = 32'h0BAD_CAFE;
        step();
        dm_bus.dm_ack = 1'b0;
        nop();
        total++; if (bus_err_out !== 1'b0 || reg_wen_out !== 1'b1 || wb_data_out !== 32'h0BAD_CAFE)
            $display("FAIL notimeout_done: got err=%b wen=%b wb=%h want 0/1/0badcafe", bus_err_out, reg_wen_out, wb_data_out); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load_sign();
        test_half_store();
        test_misaligned();
        test_done_hold();
        test_reset_mid_busy();
        test_flush_busy();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: write  in  1  pipeline advance enable; flush  in  1  kill current instruction.
REQ-004 SHALL have: exe_data  in  32  ALU result/effective address; busB  in  32  store data; pc  in  32.
REQ-005 SHALL have: memReadEn  in  4  load size mask (0001 byte, 0011 half, 1111 word, 0000 none); memWriteEn  in  4  store size mask, same encoding.
REQ-006 SHALL have: load_signed  in  1; mem_to_reg  in  1; reg_wen  in  1; reg_num  in  5.
REQ-007 SHALL have: dm_req  out  1; dm_addr  out  32; dm_we  out  4 lane write strobes; dm_wdata  out  32; dm_rdata  in  32; dm_ack  in  1.
REQ-008 SHALL have: stall_out  out  1; wb_data_out  out  32; reg_wen_out  out  1; reg_num_out  out  5; pc_out  out  32; addr_err_out  out  1; bus_err_out  out  1.

Function
REQ-009 Access SHALL be requested when (memReadEn|memWriteEn)!=0, flush=0, access aligned.
REQ-010 Misaligned: half with exe_data[0]=1, word with exe_data[1:0]!=0; SHALL issue no request, set addr_err_out=1 and reg_wen_out=0 at next capture.
REQ-011 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-012 IDLE: on requested access, dm_req=1 combinationally, next state BUSY; else stay IDLE.
REQ-013 BUSY: dm_req held 1, address/strobes/data held stable; dm_ack=1 -> capture dm_rdata; next IDLE if write=1, DONE if write=0.
REQ-014 DONE: dm_req=0, held read data used; next IDLE when write=1.
REQ-015 dm_addr SHALL be {exe_data[31:2],2'b00}; dm_we = memWriteEn << exe_data[1:0]; dm_we=0 for loads.
REQ-016 dm_wdata: word busB; half {2{busB[15:0]}}; byte {4{busB[7:0]}}.
REQ-017 Load data: lane = dm_rdata >> (8*exe_data[1:0]); byte/half sign-extended if load_signed=1 else zero-extended.
REQ-018 stall_out SHALL be 1 in IDLE with requested access and in BUSY with dm_ack=0; 0 otherwise (including BUSY with dm_ack=1 and DONE).
REQ-019 Minimum access latency: 2 cycles (1 stall cycle), ack accepted only in BUSY.
REQ-020 Output registers SHALL update at posedge when write=1 and stall_out=0: wb_data_out = mem_to_reg ? load data : exe_data; reg_num_out, pc_out pass through.
REQ-021 reg_wen_out = reg_wen & !flush & !addr_err & !bus_err.
REQ-022 Flush asserted while BUSY SHALL NOT abort the bus transaction; FSM waits for ack, result discarded (reg_wen_out=0).
REQ-023 Inputs without access SHALL pass through in one cycle, no stall.

Reset
REQ-024 rst=0 at posedge SHALL force IDLE and zero all registered outputs; dm_req=0 in the same cycle, overriding any outstanding transaction.
REQ-025 Reset SHALL take priority over write and dm_ack in the same cycle.

Configuration
REQ-026 Macro MEM_TIMEOUT_EN SHALL compile a 4-bit BUSY-cycle counter, cleared on BUSY entry.
REQ-027 With MEM_TIMEOUT_EN: counter=15 and dm_ack=0 -> dm_req dropped, next IDLE, stall_out=0 that cycle, bus_err_out=1 and reg_wen_out=0 at capture.
REQ-028 Without MEM_TIMEOUT_EN: BUSY waits indefinitely; bus_err_out tied 0.

Verification
REQ-029 Word load exe_data=0x100, ack after 3 cycles, dm_rdata=0xDEADBEEF, mem_to_reg=1 -> stall 3 cycles, wb_data_out=0xDEADBEEF, reg_wen_out=1.
REQ-030 Signed byte load exe_data=0x103, dm_rdata=0x80112233 -> wb_data_out=0xFFFFFF80; unsigned -> 0x00000080.
REQ-031 Half store exe_data=0x202, busB=0x1234ABCD -> dm_addr=0x200, dm_we=1100, dm_wdata=0xABCDABCD.
REQ-032 Word load exe_data=0x101 -> dm_req never 1, addr_err_out=1, reg_wen_out=0, no stall.
REQ-033 Ack with write=0 for 2 cycles -> DONE held, dm_req=0, wb_data_out captured when write returns 1; rst=0 mid-BUSY -> dm_req=0, outputs zero.
REQ-034 MEM_TIMEOUT_EN defined, no ack -> dm_req drops after 16 BUSY cycles, bus_err_out=1, reg_wen_out=0.
